axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_rd_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/axi_read_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read arbiter.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  localparam logic [2:0] ARSIZE_4B   = 3'b010;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Index width for a master count; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand_s;

  // Walk the ring once starting at ptr and stop at the first request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand_s    = ptr;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && req[cand_s]) begin
        grant_vld     = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        grant_vld = grant_vld;
      end
      cand_s = (cand_s == IDX_W'(N - 1)) ? '0 : cand_s + IDX_W'(1);
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-to-1 AXI read arbiter, one outstanding burst at a time.
// Optional macro AXI_RD_ARB_RID_CHECK_EN adds the sticky rid_err output.
module axi_read_arbiter
  import axi_rd_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen,
  input  logic [NUM_MASTERS*2-1:0]      m_arburst,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [NUM_MASTERS-1:0]        m_rlast,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic [3:0]                    arid,
  output logic [ADDR_W-1:0]             araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [3:0]                    rid,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
`ifdef AXI_RD_ARB_RID_CHECK_EN
  ,
  output logic                          rid_err
`endif
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [1:0]       burst_q, burst_d;
  logic [2:0]       size_q, size_d;

  logic [NUM_MASTERS-1:0] grant_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   grant_vld_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [7:0]             sel_len_s;
  logic [1:0]             sel_burst_s;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (m_arvalid),
    .ptr       (ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // One-hot AND-OR mux of the winning master's AR fields.
  always_comb begin
    sel_addr_s  = '0;
    sel_len_s   = '0;
    sel_burst_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_addr_s  = sel_addr_s  | (m_araddr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
      sel_len_s   = sel_len_s   | (m_arlen[i*8 +: 8]            & {8{grant_s[i]}});
      sel_burst_s = sel_burst_s | (m_arburst[i*2 +: 2]          & {2{grant_s[i]}});
    end
  end

  // Next-state logic: arbitrate in IDLE, hold AR until accepted, follow R until last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          state_d = ST_ADDR;
          owner_d = grant_idx_s;
          addr_d  = sel_addr_s;
          len_d   = sel_len_s;
          burst_d = sel_burst_s;
          size_d  = ARSIZE_4B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rvalid && rready && rlast) begin
          state_d = ST_IDLE;
          ptr_d   = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      burst_q <= 2'b00;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      size_q  <= size_d;
    end
  end

  // Route handshakes to the owning master only; everyone else sees zeros.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    rready    = 1'b0;
    case (state_q)
      ST_ADDR: begin
        m_arready[owner_q] = arready;
      end
      ST_DATA: begin
        m_rvalid[owner_q] = rvalid;
        m_rlast[owner_q]  = rlast;
        rready            = m_rready[owner_q];
      end
      default: begin
        rready = 1'b0;
      end
    endcase
  end

  assign arvalid = (state_q == ST_ADDR);
  assign arid    = 4'(owner_q);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arburst = burst_q;
  assign arsize  = size_q;

  // Broadcast data is forced low while reset is held so every output reads zero.
  assign m_rdata = aresetn ? rdata : '0;
  assign m_rresp = aresetn ? rresp : 2'b00;

`ifdef AXI_RD_ARB_RID_CHECK_EN
  logic rid_err_q;

  // Sticky flag for any accepted beat whose ID differs from the issued one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid_err_q <= 1'b0;
    end else if ((state_q == ST_DATA) && rvalid && rready && (rid != arid)) begin
      rid_err_q <= 1'b1;
    end else begin
      rid_err_q <= rid_err_q;
    end
  end

  assign rid_err = rid_err_q;
`else
  logic rid_unused_s;
  assign rid_unused_s = ^rid;
`endif

endmodule
